// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, combinational imem address,
// IF/ID pipeline register with freeze/flush handling, and saturating
// fetch/bubble performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      imem_pc,
    input  logic [31:0]      imem_inst,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones so long lab runs never report a wrapped value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_inst_q, if_inst_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] fetch_q, fetch_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state selection: a taken branch outranks a freeze because the
    // instruction held in IF/ID is wrong-path and must be discarded.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        fetch_d    = fetch_q;
        bubble_d   = bubble_q;
        if (branch_taken) begin
            pc_d       = {branch_addr[31:2], 2'b00};
            if_pc_d    = 32'd0;
            if_inst_d  = 32'd0;
            if_valid_d = 1'b0;
            bubble_d   = sat_inc(bubble_q);
        end else if (freeze) begin
            bubble_d   = sat_inc(bubble_q);
        end else begin
            pc_d       = pc_plus4;
            if_pc_d    = pc_plus4;
            if_inst_d  = imem_inst;
            if_valid_d = 1'b1;
            fetch_d    = sat_inc(fetch_q);
        end
    end

    // State registers; reset clears the whole stage, data included.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            if_valid_q <= 1'b0;
            fetch_q    <= '0;
            bubble_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            fetch_q    <= fetch_d;
            bubble_q   <= bubble_d;
        end
    end

    // The imem address comes straight from the PC register, so freeze and
    // branch_taken never reach it combinationally.
    assign imem_pc      = pc_q;
    assign if_id_pc     = if_pc_q;
    assign if_id_inst   = if_inst_q;
    assign if_id_valid  = if_valid_q;
    assign fetch_count  = fetch_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    localparam int          CW   = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst, freeze, branch_taken;
    logic [31:0]   branch_addr, imem_pc, imem_inst, if_id_pc, if_id_inst;
    logic          if_id_valid;
    logic [CW-1:0] fetch_count, bubble_count;

    logic [31:0] mem [0:255];

    // model state
    logic [31:0]   m_pc, m_ifpc, m_inst;
    logic          m_valid;
    logic [CW-1:0] m_fetch, m_bub;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_PC(32'd0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_pc(imem_pc), .imem_inst(imem_inst),
        .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_pc[9:2]];

    function automatic logic [108:0] dut_vec();
        return {imem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_count, bubble_count};
    endfunction

    function automatic logic [108:0] mdl_vec();
        return {m_pc, m_ifpc, m_inst, m_valid, m_fetch, m_bub};
    endfunction

    // Apply one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic r, input logic b, input logic f, input logic [31:0] a);
        logic [31:0] fetched;
        rst = r; branch_taken = b; freeze = f; branch_addr = a;
        fetched = mem[m_pc[9:2]];
        @(posedge clk);
        if (r) begin
            m_pc = 32'd0; m_ifpc = 32'd0; m_inst = 32'd0; m_valid = 1'b0;
            m_fetch = '0; m_bub = '0;
        end else if (b) begin
            m_pc = a & 32'hFFFF_FFFC;
            m_ifpc = 32'd0; m_inst = 32'd0; m_valid = 1'b0;
            if (m_bub != CMAX) m_bub = m_bub + 1'b1;
        end else if (f) begin
            if (m_bub != CMAX) m_bub = m_bub + 1'b1;
        end else begin
            m_inst  = fetched;
            m_ifpc  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_fetch != CMAX) m_fetch = m_fetch + 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if (dut_vec() !== 109'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 109'd0);
        end
    endtask

    task automatic test_sequence();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL seq_edge%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            n_tests++;
            if (if_id_pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_pc%0d: got %h expected %h", i, if_id_pc, 32'(4 * i));
            end
        end
        n_tests++;
        if ({fetch_count, bubble_count} !== {4'd3, 4'd0}) begin
            n_fail++;
            $display("FAIL seq_counts: got fetch=%0d bubble=%0d expected 3/0", fetch_count, bubble_count);
        end
    endtask

    task automatic test_first_inst();
        test_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if ({if_id_inst, if_id_valid} !== {32'hE3A00014, 1'b1}) begin
            n_fail++;
            $display("FAIL first_inst: got %h/%b expected E3A00014/1", if_id_inst, if_id_valid);
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'd0);
            n_tests++;
            if ({imem_pc, if_id_pc, if_id_inst, if_id_valid} !== {32'd12, 32'd12, mem[2], 1'b1}) begin
                n_fail++;
                $display("FAIL freeze_hold%0d: got pc=%h ifpc=%h inst=%h v=%b", i, imem_pc, if_id_pc, if_id_inst, if_id_valid);
            end
        end
        n_tests++;
        if (bubble_count !== 4'd2) begin
            n_fail++;
            $display("FAIL freeze_bubbles: got %0d expected 2", bubble_count);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if (if_id_pc !== 32'd16 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL freeze_release: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_branch_freeze();
        step(1'b0, 1'b1, 1'b1, 32'd112);
        n_tests++;
        if ({imem_pc, if_id_valid, if_id_inst} !== {32'd112, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL branch_flush: got pc=%h v=%b inst=%h expected 70/0/0", imem_pc, if_id_valid, if_id_inst);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if ({if_id_pc, if_id_inst, if_id_valid} !== {32'd116, 32'hE0804103, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_target: got pc=%h inst=%h v=%b expected 74/E0804103/1", if_id_pc, if_id_inst, if_id_valid);
        end
    endtask

    task automatic test_misaligned_wrap();
        step(1'b0, 1'b1, 1'b0, 32'h0000_0071);
        n_tests++;
        if (imem_pc !== 32'h0000_0070) begin
            n_fail++;
            $display("FAIL misaligned: got %h expected 00000070", imem_pc);
        end
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if ({imem_pc, if_id_pc, if_id_valid} !== {32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap: got pc=%h ifpc=%h v=%b expected 0/0/1", imem_pc, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h40);
        step(1'b0, 1'b0, 1'b1, 32'd0);
        n_tests++;
        if (imem_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got %h expected 00000040", imem_pc);
        end
        step(1'b1, 1'b1, 1'b1, 32'h1234);
        n_tests++;
        if (dut_vec() !== 109'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        n_tests++;
        if ({fetch_count, bubble_count} !== {4'd15, 4'd0}) begin
            n_fail++;
            $display("FAIL saturation: got fetch=%0d bubble=%0d expected 15/0", fetch_count, bubble_count);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0), $urandom);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'hE3A00014;
        mem[28] = 32'hE0804103;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        m_pc = '0; m_ifpc = '0; m_inst = '0; m_valid = 1'b0; m_fetch = '0; m_bub = '0;
        @(negedge clk);
        test_reset();
        test_sequence();
        test_freeze();
        test_branch_freeze();
        test_misaligned_wrap();
        test_reset_mid();
        test_first_inst();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM-subset pipeline.
- Holds the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles hazard freeze from ID, branch redirect/flush from EX, and keeps fetch/bubble performance counters for lab verification.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset (must be word-aligned).
CNT_W, 16, width of the fetch and bubble counters.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
freeze  in  1  hazard stall from the hazard unit: hold PC and IF/ID.
branch_taken  in  1  branch resolved taken in EX: redirect PC and flush IF/ID.
branch_addr  in  32  branch target (already computed as pc+4 + sext(imm24)<<2).
imem_pc  out  32  address to instruction memory, equal to the PC register.
imem_inst  in  32  instruction returned combinationally for imem_pc.
if_id_pc  out  32  registered PC+4 of the fetched instruction.
if_id_inst  out  32  registered instruction.
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
fetch_count  out  CNT_W  number of instructions loaded into IF/ID.
bubble_count  out  CNT_W  number of cycles IF/ID did not load new work.

Behaviour:
- Reset: when rst is 1 at a clock edge, PC <= RESET_PC. All outputs go to 0: if_id_pc, if_id_inst, if_id_valid, fetch_count, bubble_count. rst overrides all other inputs.
- imem_pc is PC directly. No added latency: the instruction is valid in the same cycle and registered at the next edge.
- PC update priority, per edge: rst > branch_taken > freeze > increment.
  - branch_taken=1: PC <= {branch_addr[31:2],2'b00}. Low two bits are forced to 0.
  - branch_taken=0, freeze=1: PC holds.
  - Otherwise: PC <= PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- IF/ID update uses the same priority:
  - branch_taken=1 (flush): if_id_inst <= 0, if_id_pc <= 0, if_id_valid <= 0. Flush wins over freeze, because the ID instruction is wrong-path.
  - freeze=1: all IF/ID fields hold, including valid.
  - Otherwise: if_id_inst <= imem_inst, if_id_pc <= PC + 4 (wraps), if_id_valid <= 1.
- Net effect: one-cycle fetch latency. After reset deassert, the first instruction appears in IF/ID at the 1st edge.
- A taken branch costs one flushed IF/ID slot in this stage. The target's instruction appears in IF/ID one edge after the redirect edge.
- fetch_count increments on every edge where IF/ID loads, i.e. not rst, not branch_taken, not freeze.
- bubble_count increments on every non-reset edge with branch_taken=1 or freeze=1. Exactly one counter moves per non-reset edge.
- Both counters saturate at 2^CNT_W-1; they never wrap.
- No combinational path from freeze/branch_taken to imem_pc. The only combinational path is imem_inst to IF/ID D-inputs.
- Reset asserted mid-stream (including during freeze or branch) behaves exactly as reset from power-up on that edge.

Test Plan:
- Reset sequencing, RESET_PC=0, memory holding the standard test program: after release, edge 1 gives if_id_pc=4, if_id_inst=0xE3A00014, valid=1. Edges 2 and 3 give if_id_pc=8 and 12. fetch_count=3, bubble_count=0.
- Freeze with PC=12: freeze=1 for 2 cycles. imem_pc stays 12. IF/ID stays at pc=12 with inst of address 8 and valid=1. bubble_count+=2. After release, next edge gives if_id_pc=16.
- Branch with simultaneous freeze: branch_taken=1, freeze=1, branch_addr=112. Next cycle: imem_pc=112, if_id_valid=0, if_id_inst=0. Following edge: if_id_pc=116, if_id_inst=0xE0804103, valid=1.
- Misaligned target and wrap-around:
  - branch_addr=0x00000071 gives imem_pc=0x00000070.
  - branch_addr=0xFFFFFFFC, then one free edge, gives imem_pc=0x00000000 and if_id_pc=0x00000000.
- Reset mid-operation: assert rst during freeze with PC=0x40. Next edge: imem_pc=0, all IF/ID fields 0, both counters 0.
- Counter saturation with CNT_W=4: run 20 unfrozen cycles. fetch_count stops at 15; bubble_count stays 0.
